mod_n_counter: RTL
==================

MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 3, counter register width in bits.
REQ-002 Parameter MODULUS SHALL be: MODULUS, default 7, count range 0..MODULUS-1; legal only for 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter SAT SHALL be: SAT, default 0, end-of-range mode; 0 = wrap, 1 = saturate.
REQ-004 Port Cp SHALL be: Cp  input  1  clock; all state updates on the rising edge.
REQ-005 Port R SHALL be: R  input  1  reset; asynchronous, active-low.
REQ-006 Port en SHALL be: en  input  1  count enable.
REQ-007 Port up SHALL be: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 Port ld SHALL be: ld  input  1  synchronous load strobe.
REQ-009 Port d SHALL be: d  input  WIDTH  load value.
REQ-010 Port q SHALL be: q  output  WIDTH  registered count value.
REQ-011 Port tc SHALL be: tc  output  1  combinational terminal count; high when en=1 and (up=1, q=MODULUS-1) or (up=0, q=0).
REQ-012 Port wrap SHALL be: wrap  output  1  registered one-cycle pulse; high in the cycle after q wrapped.

Function
REQ-013 On each rising Cp edge the priority SHALL be: ld, then en, then hold.
REQ-014 If ld=1, q SHALL take d when d < MODULUS, and MODULUS-1 otherwise (clamp); en and up are ignored in that cycle.
REQ-015 If ld=0, en=1, up=1 and q < MODULUS-1, q SHALL become q+1.
REQ-016 If ld=0, en=1, up=0 and q > 0, q SHALL become q-1.
REQ-017 With SAT=0: up at q=MODULUS-1 SHALL give q=0; down at q=0 SHALL give q=MODULUS-1.
REQ-018 With SAT=1, q SHALL hold at MODULUS-1 (up) or at 0 (down) instead of wrapping.
REQ-019 wrap SHALL be 1 for exactly the cycle following an edge on which REQ-017 applied, and 0 otherwise.
REQ-020 wrap SHALL never assert when SAT=1, on a load, or on hold.
REQ-021 Latency from ld/en sampling to q update SHALL be one Cp edge; tc is valid in the same cycle as q.
REQ-022 If en=0 or ld=1, tc SHALL be 0 regardless of q.
REQ-023 q SHALL never take a value >= MODULUS under any input sequence.
REQ-024 Changing up between cycles SHALL take effect on the next edge, with no dead cycle.

Reset
REQ-025 While R=0, q SHALL be 0 and wrap SHALL be 0, immediately and independent of Cp.
REQ-026 Reset asserted mid-count SHALL discard the count and any pending load.
REQ-027 On the first rising Cp edge after R returns to 1, normal operation per REQ-013 SHALL resume.

Configuration
REQ-028 Macro MOD_N_COUNTER_GRAY_EN, when defined, SHALL add output port g (WIDTH bits): a registered Gray-code copy of the count.
REQ-029 g SHALL be updated on the same edge as q, so that g == q ^ (q >> 1) in every cycle, and SHALL be 0 in reset.
REQ-030 When MOD_N_COUNTER_GRAY_EN is undefined, port g and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Default params, R pulse low then en=1, up=1 for 8 edges -> q = 1,2,3,4,5,6,0,1; tc=1 while q=6; wrap=1 only in the cycle q=0.
REQ-032 en=1, up=0 from q=0 for 3 edges -> q = 6,5,4; wrap=1 in the cycle q=6.
REQ-033 ld=1 with d=5, en=1 -> q=5 next cycle, wrap=0; ld=1 with d=7 -> q=6 (clamp).
REQ-034 SAT=1, up=1 from q=5 for 3 edges -> q = 6,6,6, tc=1 throughout, wrap stays 0.
REQ-035 R driven low between Cp edges while q=4 -> q=0 at once with no clock edge; after release, en=1 gives q=1 on the first edge.
REQ-036 MOD_N_COUNTER_GRAY_EN defined, full up cycle -> g = 000,001,011,010,110,111,101,000.

Source files
------------

// File: rtl/mod_n_counter.sv
// ---------------------------------------------------------------------------
// mod_n_counter
//   Up/down modulo-N counter with synchronous clamped load, optional
//   end-of-range saturation, a combinational terminal-count flag and a
//   registered wrap pulse.
//
//   Optional feature macro: MOD_N_COUNTER_GRAY_EN
//     When defined, adds output g, a registered Gray-code copy of q.
//
//   Parameters
//     WIDTH    counter width in bits
//     MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//     SAT      0 = wrap at the ends of the range, 1 = saturate
//
//   Ports
//     Cp    in   clock, rising edge
//     R     in   asynchronous reset, active low
//     en    in   count enable
//     up    in   direction, 1 = increment, 0 = decrement
//     ld    in   synchronous load strobe (priority over en)
//     d     in   load value, clamped to MODULUS-1
//     q     out  registered count
//     tc    out  terminal count (combinational)
//     wrap  out  one-cycle pulse in the cycle after q wrapped
//     g     out  registered Gray code of q (MOD_N_COUNTER_GRAY_EN only)
// ---------------------------------------------------------------------------
module mod_n_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 7,
    parameter bit SAT     = 1'b0
) (
    input  logic             Cp,
    input  logic             R,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
`ifdef MOD_N_COUNTER_GRAY_EN
    output logic             wrap,
    output logic [WIDTH-1:0] g
`else
    output logic             wrap
`endif
);

    // MODULUS may equal 2**WIDTH, so the load comparison needs one extra bit.
    localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        if (ld) begin
            w_q_nxt = ({1'b0, d} < LP_MOD) ? d : LP_MAX;
        end else if (en) begin
            if (up) begin
                if (r_q < LP_MAX) begin
                    w_q_nxt = r_q + WIDTH'(1);
                end else if (SAT == 1'b0) begin
                    w_q_nxt    = '0;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                if (r_q != '0) begin
                    w_q_nxt = r_q - WIDTH'(1);
                end else if (SAT == 1'b0) begin
                    w_q_nxt    = LP_MAX;
                    w_wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Cp or negedge R) begin
        if (!R) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

`ifdef MOD_N_COUNTER_GRAY_EN
    logic [WIDTH-1:0] r_g;

    // Encoded from the next count so g lands on the same edge as q.
    always_ff @(posedge Cp or negedge R) begin
        if (!R) begin
            r_g <= '0;
        end else begin
            r_g <= w_q_nxt ^ (w_q_nxt >> 1);
        end
    end

    assign g = r_g;
`endif

    assign q    = r_q;
    assign wrap = r_wrap;
    assign tc   = en & ~ld & (up ? (r_q == LP_MAX) : (r_q == '0));

endmodule
